pc_unit: RTL and testbench

//  Parametrised program-counter generator for the pipeline fetch stage.

---
 rtl/pc_unit_if.sv | 39 +++
 rtl/pc_unit.sv | 111 +++++++++++
 tb/tb_pc_unit.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/pc_unit_if.sv
// Fetch-control bus between the pipeline control logic and the PC generator.
// The master issues stall/redirect/exception requests; the slave returns the fetch PC.
interface pc_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic             stall;
  logic             redirect_valid;
  logic [WIDTH-1:0] redirect_target;
  logic             exc_valid;
  logic [WIDTH-1:0] pc_out;
  logic             pc_valid;
  logic [WIDTH-1:0] pc_seq;
  logic             flush_out;
  logic             misalign;

  modport master (
    output stall,
    output redirect_valid,
    output redirect_target,
    output exc_valid,
    input  pc_out,
    input  pc_valid,
    input  pc_seq,
    input  flush_out,
    input  misalign
  );

  modport slave (
    input  stall,
    input  redirect_valid,
    input  redirect_target,
    input  exc_valid,
    output pc_out,
    output pc_valid,
    output pc_seq,
    output flush_out,
    output misalign
  );
endinterface

// File: rtl/pc_unit.sv
// Fetch-stage program counter: boot hold, sequential step, redirect/exception load,
// and a pending-redirect buffer that survives stalls. Redirect-to-PC latency is 1 edge.
module pc_unit #(
  parameter int unsigned          WIDTH      = 32,
  parameter logic [WIDTH-1:0]     RESET_PC   = '0,
  parameter logic [WIDTH-1:0]     EXC_VECTOR = WIDTH'(32'h0000_0180),
  parameter int unsigned          INC        = 4,
  parameter int unsigned          ALIGN_BITS = 2
) (
  input  logic        clk,
  input  logic        rst,
  pc_unit_if.slave    bus
);

  localparam logic [WIDTH-1:0] INC_W      = WIDTH'(INC);
  localparam logic [WIDTH-1:0] ALIGN_MASK = WIDTH'((64'd1 << ALIGN_BITS) - 64'd1);

  typedef enum logic {
    BOOT,
    RUN
  } state_t;

  typedef enum logic [1:0] {
    P_NONE,
    P_REDIR,
    P_EXC
  } pend_t;

  state_t           state_q, state_d;
  pend_t            pend_q, pend_d;
  logic [WIDTH-1:0] pend_tgt_q, pend_tgt_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic             flush_q, flush_d;
  logic             mis_q, mis_d;
  logic             tgt_misaligned;
  logic             exc_req;

  assign tgt_misaligned = |(bus.redirect_target & ALIGN_MASK);
  // A misaligned redirect is indistinguishable from an exception request.
  assign exc_req        = bus.exc_valid || (bus.redirect_valid && tgt_misaligned);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= BOOT;
      pend_q     <= P_NONE;
      pend_tgt_q <= '0;
      pc_q       <= RESET_PC;
      flush_q    <= 1'b0;
      mis_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      pend_tgt_q <= pend_tgt_d;
      pc_q       <= pc_d;
      flush_q    <= flush_d;
      mis_q      <= mis_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pend_d     = pend_q;
    pend_tgt_d = pend_tgt_q;
    pc_d       = pc_q;
    flush_d    = 1'b0;
    mis_d      = 1'b0;

    case (state_q)
      BOOT: begin
        state_d = RUN;
        pc_d    = RESET_PC;
        pend_d  = P_NONE;
      end
      RUN: begin
        if (exc_req) begin
          // Misalign is reported only when the redirect itself was the cause.
          mis_d = !bus.exc_valid && bus.redirect_valid && tgt_misaligned;
          if (!bus.stall) begin
            pc_d    = EXC_VECTOR;
            flush_d = 1'b1;
            pend_d  = P_NONE;
          end else begin
            pend_d  = P_EXC;
          end
        end else if (bus.redirect_valid) begin
          if (!bus.stall) begin
            pc_d    = bus.redirect_target;
            flush_d = 1'b1;
            pend_d  = P_NONE;
          end else if (pend_q != P_EXC) begin
            pend_d     = P_REDIR;
            pend_tgt_d = bus.redirect_target;
          end
        end else if (!bus.stall && pend_q != P_NONE) begin
          pc_d    = (pend_q == P_EXC) ? EXC_VECTOR : pend_tgt_q;
          flush_d = 1'b1;
          pend_d  = P_NONE;
        end else if (!bus.stall) begin
          pc_d = pc_q + INC_W;
        end
      end
    endcase
  end

  assign bus.pc_out    = pc_q;
  assign bus.pc_valid  = (state_q == RUN);
  assign bus.pc_seq    = pc_q + INC_W;
  assign bus.flush_out = flush_q;
  assign bus.misalign  = mis_q;

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: a 32-bit instance for sequencing/redirect/exception
// cases and an 8-bit instance for wrap-around and reset-with-pending.
module tb_pc_unit;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  pc_unit_if #(.WIDTH(32)) bus32 ();
  pc_unit_if #(.WIDTH(8))  bus8 ();

  pc_unit #(
    .WIDTH(32), .RESET_PC(32'h0), .EXC_VECTOR(32'h180), .INC(4), .ALIGN_BITS(2)
  ) dut32 (
    .clk(clk), .rst(rst), .bus(bus32)
  );

  pc_unit #(
    .WIDTH(8), .RESET_PC(8'h40), .EXC_VECTOR(8'h80), .INC(4), .ALIGN_BITS(2)
  ) dut8 (
    .clk(clk), .rst(rst), .bus(bus8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] pc, input logic flush);
    check({tag, ".pc"}, bus32.pc_out, pc);
    check({tag, ".flush"}, {31'b0, bus32.flush_out}, {31'b0, flush});
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus32.stall = 1'b0; bus32.redirect_valid = 1'b0; bus32.redirect_target = '0; bus32.exc_valid = 1'b0;
    bus8.stall  = 1'b0; bus8.redirect_valid  = 1'b0; bus8.redirect_target  = '0; bus8.exc_valid  = 1'b0;

    // T1: reset and boot sequence
    repeat (3) step();
    chk32("rst", 32'h0, 1'b0);
    check("rst.valid", {31'b0, bus32.pc_valid}, 32'h0);
    check("rst.mis", {31'b0, bus32.misalign}, 32'h0);
    rst = 1'b0;
    step();
    chk32("boot", 32'h0, 1'b0);
    check("boot.valid", {31'b0, bus32.pc_valid}, 32'h1);
    step(); chk32("seq4", 32'h4, 1'b0);
    step(); chk32("seq8", 32'h8, 1'b0);
    step(); chk32("seqC", 32'hC, 1'b0);
    check("pc_seq", bus32.pc_seq, 32'h10);
    step(); chk32("seq10", 32'h10, 1'b0);

    // T2: unstalled redirect
    bus32.redirect_valid = 1'b1; bus32.redirect_target = 32'h100;
    step(); chk32("t2.redir", 32'h100, 1'b1);
    bus32.redirect_valid = 1'b0;
    step(); chk32("t2.next", 32'h104, 1'b0);

    // T3: newer redirect overwrites pending while stalled
    bus32.redirect_valid = 1'b1; bus32.redirect_target = 32'h20;
    step(); chk32("t3.to20", 32'h20, 1'b1);
    bus32.stall = 1'b1; bus32.redirect_target = 32'h200;
    step(); chk32("t3.hold1", 32'h20, 1'b0);
    bus32.redirect_target = 32'h300;
    step(); chk32("t3.hold2", 32'h20, 1'b0);
    bus32.redirect_valid = 1'b0;
    step(); chk32("t3.hold3", 32'h20, 1'b0);
    bus32.stall = 1'b0;
    step(); chk32("t3.release", 32'h300, 1'b1);
    step(); chk32("t3.next", 32'h304, 1'b0);

    // T4: pending exception not displaced by later redirect
    bus32.stall = 1'b1; bus32.exc_valid = 1'b1;
    step(); chk32("t4.hold1", 32'h304, 1'b0);
    bus32.exc_valid = 1'b0; bus32.redirect_valid = 1'b1; bus32.redirect_target = 32'h400;
    step(); chk32("t4.hold2", 32'h304, 1'b0);
    bus32.redirect_valid = 1'b0; bus32.stall = 1'b0;
    step(); chk32("t4.release", 32'h180, 1'b1);
    step(); chk32("t4.next", 32'h184, 1'b0);

    // T5: misaligned redirect, unstalled
    bus32.redirect_valid = 1'b1; bus32.redirect_target = 32'h102;
    step(); chk32("t5.exc", 32'h180, 1'b1);
    check("t5.mis", {31'b0, bus32.misalign}, 32'h1);
    bus32.redirect_valid = 1'b0;
    step(); chk32("t5.next", 32'h184, 1'b0);
    check("t5.mis_clr", {31'b0, bus32.misalign}, 32'h0);

    // Misaligned redirect under stall: pulse at capture, load deferred
    bus32.stall = 1'b1; bus32.redirect_valid = 1'b1; bus32.redirect_target = 32'h206;
    step(); chk32("mstall.hold", 32'h184, 1'b0);
    check("mstall.mis", {31'b0, bus32.misalign}, 32'h1);
    bus32.redirect_valid = 1'b0;
    step(); check("mstall.mis_clr", {31'b0, bus32.misalign}, 32'h0);
    bus32.stall = 1'b0;
    step(); chk32("mstall.release", 32'h180, 1'b1);

    // Redirect arriving as stall drops beats the pending one
    bus32.stall = 1'b1; bus32.redirect_valid = 1'b1; bus32.redirect_target = 32'h500;
    step(); chk32("newer.hold", 32'h180, 1'b0);
    bus32.stall = 1'b0; bus32.redirect_target = 32'h600;
    step(); chk32("newer.load", 32'h600, 1'b1);
    bus32.redirect_valid = 1'b0;
    step(); chk32("newer.next", 32'h604, 1'b0);
    check("newer.seq", bus32.pc_seq, 32'h608);

    // T6: 8-bit wrap and reset with pending redirect
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    check("w8.boot", {24'b0, bus8.pc_out}, 32'h40);
    bus8.redirect_valid = 1'b1; bus8.redirect_target = 8'hFC;
    step();
    check("w8.fc", {24'b0, bus8.pc_out}, 32'hFC);
    check("w8.seq_wrap", {24'b0, bus8.pc_seq}, 32'h00);
    bus8.redirect_valid = 1'b0;
    step();
    check("w8.wrap", {24'b0, bus8.pc_out}, 32'h00);
    check("w8.wrap_flush", {31'b0, bus8.flush_out}, 32'h0);
    bus8.stall = 1'b1; bus8.redirect_valid = 1'b1; bus8.redirect_target = 8'h20;
    step();
    check("w8.pend_hold", {24'b0, bus8.pc_out}, 32'h00);
    bus8.redirect_valid = 1'b0;
    rst = 1'b1;
    step();
    check("w8.rst_pc", {24'b0, bus8.pc_out}, 32'h40);
    check("w8.rst_valid", {31'b0, bus8.pc_valid}, 32'h0);
    rst = 1'b0; bus8.stall = 1'b0;
    step();
    check("w8.reboot", {24'b0, bus8.pc_out}, 32'h40);
    check("w8.reboot_flush", {31'b0, bus8.flush_out}, 32'h0);
    step();
    check("w8.after", {24'b0, bus8.pc_out}, 32'h44);
    check("w8.after_flush", {31'b0, bus8.flush_out}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
